// File: rtl/oib_ib_receiver.sv
// oib_ib_receiver: inbound 8b+odd-parity byte-bus receiver with length-header framing and output FIFO.
// Define OIB_IB_RECEIVER_STATS_EN to build the parity-error / drop statistics counters.
module oib_ib_receiver #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             ext_rst_n,
    input  logic [7:0]       ib_data,
    input  logic             ib_pty,
    output logic [7:0]       rx_data,
    output logic             rx_first,
    output logic             rx_last,
    output logic             rx_err,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic             cnt_clr,
    output logic             in_frame,
    output logic [CNT_W-1:0] parity_err_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0]   occ_t;
    typedef logic [AW-1:0] ptr_t;
    typedef struct packed {
        logic       first;
        logic       last;
        logic       err;
        logic [7:0] data;
    } entry_t;
    typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

    logic [7:0] in_data;
    logic       in_pty;
    logic       good;

    state_t     state_q, state_d;
    logic [3:0] rem_q, rem_d;
    logic       push, pop, pe_inc, drop_inc, admit;
    entry_t     push_entry;
    occ_t       occ_q, free, need;
    ptr_t       wr_ptr, rd_ptr;
    entry_t     mem [DEPTH];
    entry_t     head;

    // Reset value 0x00/pty=1 is a well-formed idle filler byte.
    always_ff @(posedge clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            in_data <= 8'h00;
            in_pty  <= 1'b1;
        end else begin
            in_data <= ib_data;
            in_pty  <= ib_pty;
        end
    end

    assign good = ^{in_pty, in_data};

    // Admission looks at occupancy before this cycle's pop, so it never over-commits.
    assign free  = occ_t'(DEPTH) - occ_q;
    assign need  = occ_t'(in_data[3:0]) + occ_t'(1);
    assign admit = (free >= need);

    always_ff @(posedge clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            state_q <= IDLE;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        push       = 1'b0;
        push_entry = '0;
        pe_inc     = 1'b0;
        drop_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!good) begin
                    pe_inc = 1'b1;
                end else if (in_data != 8'h00) begin
                    if (admit) begin
                        push       = 1'b1;
                        push_entry = '{first: 1'b1, last: (in_data[3:0] == 4'd0), err: 1'b0, data: in_data};
                        if (in_data[3:0] != 4'd0) begin
                            state_d = PAYLOAD;
                            rem_d   = in_data[3:0];
                        end
                    end else begin
                        drop_inc = 1'b1;
                        if (in_data[3:0] != 4'd0) begin
                            state_d = DROP;
                            rem_d   = in_data[3:0];
                        end
                    end
                end
            end
            PAYLOAD: begin
                push  = 1'b1;
                rem_d = rem_q - 4'd1;
                if (good) begin
                    push_entry = '{first: 1'b0, last: (rem_q == 4'd1), err: 1'b0, data: in_data};
                    if (rem_q == 4'd1) state_d = IDLE;
                end else begin
                    // Truncate the frame at the bad byte and discard the remainder.
                    push_entry = '{first: 1'b0, last: 1'b1, err: 1'b1, data: in_data};
                    pe_inc     = 1'b1;
                    state_d    = (rem_q == 4'd1) ? IDLE : DROP;
                end
            end
            DROP: begin
                rem_d = rem_q - 4'd1;
                if (rem_q == 4'd1) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rem_d   = 4'd0;
            end
        endcase
    end

    assign in_frame = (state_q != IDLE);

    assign rx_valid = (occ_q != '0);
    assign pop      = rx_valid & rx_ready;

    always_ff @(posedge clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            occ_q <= occ_q + occ_t'(push) - occ_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (ext_rst_n) assert (!(push && occ_q == occ_t'(DEPTH)));
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign head     = rx_valid ? mem[rd_ptr] : '0;
    assign rx_data  = head.data;
    assign rx_first = head.first;
    assign rx_last  = head.last;
    assign rx_err   = head.err;

`ifdef OIB_IB_RECEIVER_STATS_EN
    logic [CNT_W-1:0] pe_q, dr_q;

    always_ff @(posedge clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            pe_q <= '0;
            dr_q <= '0;
        end else if (cnt_clr) begin
            pe_q <= '0;
            dr_q <= '0;
        end else begin
            if (pe_inc && pe_q != '1)   pe_q <= pe_q + CNT_W'(1);
            if (drop_inc && dr_q != '1) dr_q <= dr_q + CNT_W'(1);
        end
    end

    assign parity_err_cnt = pe_q;
    assign drop_cnt       = dr_q;
`else
    logic unused_stats;
    assign unused_stats   = ^{cnt_clr, pe_inc, drop_inc};
    assign parity_err_cnt = '0;
    assign drop_cnt       = '0;
`endif

endmodule

// File: tb/tb_oib_ib_receiver.sv
// Bench for oib_ib_receiver: directed table, hand-written corner sequences and randomized traffic vs a frame-level model.
module tb_oib_ib_receiver;
    localparam int DEPTH = 16;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef OIB_IB_RECEIVER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             ext_rst_n = 1'b1;
    logic [7:0]       ib_data = 8'h00;
    logic             ib_pty = 1'b1;
    logic [7:0]       rx_data;
    logic             rx_first, rx_last, rx_err, rx_valid;
    logic             rx_ready = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             in_frame;
    logic [CNT_W-1:0] parity_err_cnt, drop_cnt;

    oib_ib_receiver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .ext_rst_n(ext_rst_n), .ib_data(ib_data), .ib_pty(ib_pty),
        .rx_data(rx_data), .rx_first(rx_first), .rx_last(rx_last), .rx_err(rx_err),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .cnt_clr(cnt_clr), .in_frame(in_frame),
        .parity_err_cnt(parity_err_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       first;
        bit       last;
        bit       err;
        bit [7:0] data;
    } ent_t;

    typedef struct {
        bit [7:0] d;
        bit       g;
        bit       ev;
        bit [7:0] ed;
        bit       ef, el, ee, eif;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Frame-level model: bytes left in the current frame and whether they are being kept.
    ent_t     q[$];
    int       left = 0;
    bit       keep = 1'b0;
    bit [7:0] reg_d = 8'h00;
    bit       reg_g = 1'b1;
    int       m_pe = 0;
    int       m_dr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        left  = 0;
        keep  = 1'b0;
        reg_d = 8'h00;
        reg_g = 1'b1;
        m_pe  = 0;
        m_dr  = 0;
    endtask

    task automatic model_edge(input bit rdy, input bit clr);
        int   occ;
        bit   do_push;
        bit   inc_pe;
        bit   inc_dr;
        ent_t e;
        occ     = q.size();
        do_push = 1'b0;
        inc_pe  = 1'b0;
        inc_dr  = 1'b0;
        e       = '{first: 1'b0, last: 1'b0, err: 1'b0, data: reg_d};
        if (left == 0) begin
            if (!reg_g) inc_pe = 1'b1;
            else if (reg_d != 8'h00) begin
                if (DEPTH - occ >= int'(reg_d[3:0]) + 1) begin
                    do_push = 1'b1;
                    e.first = 1'b1;
                    e.last  = (reg_d[3:0] == 4'd0);
                    keep    = 1'b1;
                end else begin
                    inc_dr = 1'b1;
                    keep   = 1'b0;
                end
                left = int'(reg_d[3:0]);
            end
        end else begin
            if (keep) begin
                do_push = 1'b1;
                e.last  = (left == 1) || !reg_g;
                e.err   = !reg_g;
                if (!reg_g) begin
                    inc_pe = 1'b1;
                    keep   = 1'b0;
                end
            end
            left--;
        end
        if (occ > 0 && rdy) void'(q.pop_front());
        if (do_push) q.push_back(e);
        if (clr) begin
            m_pe = 0;
            m_dr = 0;
        end else begin
            if (inc_pe && m_pe < CMAX) m_pe++;
            if (inc_dr && m_dr < CMAX) m_dr++;
        end
    endtask

    // Compare outputs against the model, drive one cycle of inputs, advance the model and the clock.
    task automatic step(input bit [7:0] d, input bit g, input bit rdy, input bit clr);
        bit mv;
        mv = (q.size() != 0);
        chk("rx_valid", rx_valid, mv);
        if (mv) begin
            chk("rx_data", rx_data, q[0].data);
            chk("rx_first", rx_first, q[0].first);
            chk("rx_last", rx_last, q[0].last);
            chk("rx_err", rx_err, q[0].err);
        end
        chk("in_frame", in_frame, left != 0);
        chk("parity_err_cnt", parity_err_cnt, STATS ? m_pe : 0);
        chk("drop_cnt", drop_cnt, STATS ? m_dr : 0);
        ib_data  = d;
        ib_pty   = g ? ~(^d) : (^d);
        rx_ready = rdy;
        cnt_clr  = clr;
        model_edge(rdy, clr);
        reg_d = d;
        reg_g = g;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        ext_rst_n = 1'b0;
        #1;
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_first", rx_first, 0);
        chk("rst_rx_last", rx_last, 0);
        chk("rst_rx_err", rx_err, 0);
        chk("rst_in_frame", in_frame, 0);
        chk("rst_parity_err_cnt", parity_err_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        ext_rst_n = 1'b1;
    endtask

    vec_t tbl[18];

    function automatic vec_t mk(input bit [7:0] d, input bit g, input bit ev, input bit [7:0] ed,
                                input bit ef, input bit el, input bit ee, input bit eif);
        vec_t v;
        v = '{d: d, g: g, ev: ev, ed: ed, ef: ef, el: el, ee: ee, eif: eif};
        return v;
    endfunction

    initial begin
        int n;
        tbl[0]  = mk(8'h03, 1, 0, 8'h00, 0, 0, 0, 0);
        tbl[1]  = mk(8'h11, 1, 0, 8'h00, 0, 0, 0, 0);
        tbl[2]  = mk(8'h22, 1, 1, 8'h03, 1, 0, 0, 1);
        tbl[3]  = mk(8'h33, 1, 1, 8'h11, 0, 0, 0, 1);
        tbl[4]  = mk(8'h00, 1, 1, 8'h22, 0, 0, 0, 1);
        tbl[5]  = mk(8'h00, 1, 1, 8'h33, 0, 1, 0, 0);
        tbl[6]  = mk(8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
        tbl[7]  = mk(8'h10, 1, 0, 8'h00, 0, 0, 0, 0);
        tbl[8]  = mk(8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
        tbl[9]  = mk(8'h00, 1, 1, 8'h10, 1, 1, 0, 0);
        tbl[10] = mk(8'h04, 1, 0, 8'h00, 0, 0, 0, 0);
        tbl[11] = mk(8'hA0, 1, 0, 8'h00, 0, 0, 0, 0);
        tbl[12] = mk(8'hA1, 0, 1, 8'h04, 1, 0, 0, 1);
        tbl[13] = mk(8'hB0, 1, 1, 8'hA0, 0, 0, 0, 1);
        tbl[14] = mk(8'hB1, 1, 1, 8'hA1, 0, 1, 1, 1);
        tbl[15] = mk(8'h00, 1, 0, 8'h00, 0, 0, 0, 1);
        tbl[16] = mk(8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
        tbl[17] = mk(8'h00, 1, 0, 8'h00, 0, 0, 0, 0);

        // Reset values, idle filler, then the directed framing table.
        #3;
        do_reset();
        for (int i = 0; i < 20; i++) step(8'h00, 1, 1, 0);
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("tbl%0d_valid", i), rx_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_data", i), rx_data, tbl[i].ed);
                chk($sformatf("tbl%0d_first", i), rx_first, tbl[i].ef);
                chk($sformatf("tbl%0d_last", i), rx_last, tbl[i].el);
                chk($sformatf("tbl%0d_err", i), rx_err, tbl[i].ee);
            end
            chk($sformatf("tbl%0d_in_frame", i), in_frame, tbl[i].eif);
            step(tbl[i].d, tbl[i].g, 1, 0);
        end
        chk("tbl_parity_err_cnt", parity_err_cnt, STATS ? 1 : 0);
        chk("tbl_drop_cnt", drop_cnt, 0);

        // Admission: 14 queued, a 3-entry frame is rejected, a 2-entry frame then fills to 16.
        do_reset();
        step(8'h00, 1, 0, 0);
        step(8'h00, 1, 0, 0);
        step(8'h0D, 1, 0, 0);
        for (int i = 0; i < 13; i++) step(8'h40 + 8'(i), 1, 0, 0);
        step(8'h02, 1, 0, 0);
        step(8'h55, 1, 0, 0);
        step(8'h66, 1, 0, 0);
        step(8'h01, 1, 0, 0);
        step(8'h77, 1, 0, 0);
        step(8'h00, 1, 0, 0);
        step(8'h00, 1, 0, 0);
        chk("adm_drop_cnt", drop_cnt, STATS ? 1 : 0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (rx_valid) n++;
            step(8'h00, 1, 1, 0);
        end
        chk("adm_drained_entries", n, 16);

        // Reset in the middle of a 0x05 frame; trailing payload is reparsed from IDLE.
        do_reset();
        for (int i = 0; i < 3; i++) step(8'h00, 1, 0, 0);
        step(8'h05, 1, 0, 0);
        step(8'h11, 1, 0, 0);
        step(8'h22, 1, 0, 0);
        chk("pre_rst_valid", rx_valid, 1);
        chk("pre_rst_in_frame", in_frame, 1);
        do_reset();
        step(8'h33, 1, 0, 0);
        step(8'h44, 1, 0, 0);
        step(8'h55, 1, 0, 0);
        step(8'h00, 1, 0, 0);
        step(8'h00, 1, 0, 0);
        chk("post_rst_in_frame", in_frame, 0);
        for (int i = 0; i < 8; i++) step(8'h00, 1, 1, 0);

        // Saturation of the parity-error counter and clear priority over an increment.
        do_reset();
        for (int i = 0; i < 20; i++) step(8'h00, 0, 1, 0);
        step(8'h00, 1, 1, 0);
        step(8'h00, 1, 1, 0);
        chk("sat_parity_err_cnt", parity_err_cnt, STATS ? CMAX : 0);
        step(8'h00, 0, 1, 0);
        step(8'h00, 1, 1, 1);
        chk("clr_parity_err_cnt", parity_err_cnt, 0);
        step(8'h00, 1, 1, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit [7:0] d;
            d = ($urandom_range(0, 99) < 50) ? 8'h00 : 8'($urandom);
            step(d, $urandom_range(0, 99) < 92, $urandom_range(0, 99) < 60, $urandom_range(0, 199) == 0);
        end
        for (int i = 0; i < 40; i++) step(8'h00, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
